data_bus_fabric: RTL and testbench

Parametrised data-side interconnect between the CPU data port and `NUM_SLAVES` memory-mapped targets (ROM, RAM, text RAM, future peripherals). It replaces the fixed two-bit top-address decode with per-slave base/mask regions and per-slave programmable wait states. It registers the whole transaction behind a request/ready handshake and reports unmapped accesses through an error response, a latched error address and a saturating error counter.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_addr_decode.sv | 35 +++
 rtl/data_bus_fabric.sv | 135 +++++++++++++
 tb/tb_data_bus_fabric.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the data-side bus fabric.
// Also holds a small helper for sizing slave-index fields.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bus_state_t;

  localparam int WAIT_W    = 4;
  localparam int ERR_CNT_W = 8;

  // Width of a slave index; a single slave still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address decoder.
// When regions overlap, the lowest-numbered matching slave wins.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  localparam int IDX_W = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  logic [NUM_SLAVES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = (addr & SLAVE_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                         == SLAVE_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Scan from the top down so the lowest match is the last one written.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/data_bus_fabric.sv
// CPU data-port interconnect: registered request/ready transactions to
// base/mask-decoded slaves with per-slave wait states and error tracking.
module data_bus_fabric
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'hE000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hE000_0000, 32'hE000_0000, 32'hC000_0000, 32'h8000_0000},
  parameter logic [NUM_SLAVES*WAIT_W-1:0] SLAVE_WAIT = '0
) (
  input  logic                                 sys_clk,
  input  logic                                 rst,
  input  logic                                 m_req,
  input  logic [ADDR_WIDTH-1:0]                m_addr,
  input  logic [DATA_WIDTH-1:0]                m_wdata,
  input  logic [DATA_WIDTH/8-1:0]              m_wstrb,
  output logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic                                 m_err,
  output logic [NUM_SLAVES-1:0]                s_sel,
  output logic [ADDR_WIDTH-1:0]                s_addr,
  output logic [DATA_WIDTH-1:0]                s_wdata,
  output logic [NUM_SLAVES*(DATA_WIDTH/8)-1:0] s_wstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_rdata,
  output logic [ADDR_WIDTH-1:0]                err_addr,
  output logic [ERR_CNT_W-1:0]                 err_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = idx_width(NUM_SLAVES);

  bus_state_t              state_reg;
  logic [WAIT_W-1:0]       cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    err_reg;
  logic [ADDR_WIDTH-1:0]   err_addr_reg;
  logic [ERR_CNT_W-1:0]    err_count_reg;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [DATA_WIDTH-1:0]   rdata_arr [NUM_SLAVES];
  logic [WAIT_W-1:0]       wait_arr  [NUM_SLAVES];

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_unpack
      assign rdata_arr[gi] = s_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign wait_arr[gi]  = SLAVE_WAIT[gi*WAIT_W +: WAIT_W];
    end
  endgenerate

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      err_addr_reg  <= '0;
      err_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m_req) begin
            addr_reg  <= m_addr;
            wdata_reg <= m_wdata;
            wstrb_reg <= m_wstrb;
            if (dec_hit) begin
              idx_reg   <= dec_idx;
              cnt_reg   <= wait_arr[dec_idx];
              err_reg   <= 1'b0;
              state_reg <= ACCESS;
            end else begin
              err_addr_reg <= m_addr;
              if (err_count_reg != '1) err_count_reg <= err_count_reg + 1'b1;
              rdata_reg <= '0;
              err_reg   <= 1'b1;
              state_reg <= RESP;
            end
          end
        end
        ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            rdata_reg <= (wstrb_reg == '0) ? rdata_arr[idx_reg] : '0;
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes are also masked by rst so an aborted access never writes.
  always_comb begin
    s_sel   = '0;
    s_wstrb = '0;
    if (state_reg == ACCESS) begin
      s_sel[idx_reg] = 1'b1;
      if (cnt_reg == '0 && !rst) s_wstrb[idx_reg*STRB_WIDTH +: STRB_WIDTH] = wstrb_reg;
    end
  end

  assign m_ready   = (state_reg == RESP);
  assign m_rdata   = rdata_reg;
  assign m_err     = err_reg;
  assign s_addr    = addr_reg;
  assign s_wdata   = wdata_reg;
  assign err_addr  = err_addr_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_data_bus_fabric.sv
// Directed self-checking bench for data_bus_fabric: reads, writes, overlap,
// unmapped accesses with counter saturation, reset abort and back-to-back.
module tb_data_bus_fabric;

  logic         sys_clk;
  logic         rst;
  logic         m_req;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [3:0]   m_wstrb;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_sel;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [15:0]  s_wstrb;
  logic [127:0] s_rdata;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  // Slave map: 0 = 0x0-0x3FFFFFFF W3, 1 = 0x8xxxxxxx W0,
  // 2 = 0xExxxxxxx W1, 3 = 0xC0000000-0xFFFFFFFF W5 (overlaps slave 2).
  // 0x40000000-0x7FFFFFFF is unmapped.
  data_bus_fabric #(
    .NUM_SLAVES (4),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SLAVE_BASE ({32'hC000_0000, 32'hE000_0000, 32'h8000_0000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hC000_0000, 32'hE000_0000, 32'hC000_0000, 32'hC000_0000}),
    .SLAVE_WAIT ({4'd5, 4'd1, 4'd0, 4'd3})
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issues one transaction from IDLE and records what was observed, then
  // returns to IDLE. lat counts cycles after the accepting edge (first = 1).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output int lat,
                         output int sel_cycles, output logic [3:0] sel_or,
                         output int wstrb_cycles, output logic [15:0] wstrb_or,
                         output int wstrb_at, output logic [31:0] rdata,
                         output logic err);
    lat = 0; sel_cycles = 0; sel_or = '0; wstrb_cycles = 0; wstrb_or = '0;
    wstrb_at = 0; rdata = 'x; err = 1'bx;
    m_addr = addr; m_wdata = wdata; m_wstrb = strb; m_req = 1'b1;
    tick();
    m_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (s_sel != 4'd0) begin sel_cycles++; sel_or |= s_sel; end
      if (s_wstrb != 16'd0) begin wstrb_cycles++; wstrb_or |= s_wstrb; wstrb_at = c; end
      if (m_ready) begin lat = c; rdata = m_rdata; err = m_err; break; end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    tick(); tick(); tick();
    checks++;
    if ({m_ready, m_err, s_sel, s_wstrb} !== 22'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b err=%b sel=%b wstrb=%h required all 0",
               m_ready, m_err, s_sel, s_wstrb);
    end
    checks++;
    if ({m_rdata, s_addr, s_wdata, err_addr, err_count} !== 136'd0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h eaddr=%h ecnt=%0d required all 0",
               m_rdata, s_addr, s_wdata, err_addr, err_count);
    end
    rst = 1'b0;
    tick();
    $display("txn reset: outputs idle after reset");
  endtask

  task automatic test_read();
    int lat, selc, wsc, wsat; logic [3:0] selo; logic [15:0] wso; logic [31:0] rd; logic er;
    run_txn(32'h8000_0010, 32'h0, 4'h0, lat, selc, selo, wsc, wso, wsat, rd, er);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d required 2", lat); end
    checks++;
    if (selc !== 1 || selo !== 4'b0010) begin
      errors++; $display("FAIL read_sel: got %0d cycles sel=%b required 1 cycle 0010", selc, selo);
    end
    checks++;
    if (wsc !== 0) begin errors++; $display("FAIL read_wstrb: got %0d strobe cycles required 0", wsc); end
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++; $display("FAIL read_data: got %h err=%b required deadbeef err=0", rd, er);
    end
    $display("txn read slave1 addr=80000010 lat=%0d rdata=%h err=%b", lat, rd, er);
  endtask

  task automatic test_write();
    int lat, selc, wsc, wsat; logic [3:0] selo; logic [15:0] wso; logic [31:0] rd; logic er;
    run_txn(32'h0000_0100, 32'h1234_5678, 4'b0011, lat, selc, selo, wsc, wso, wsat, rd, er);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL write_latency: got %0d required 5", lat); end
    checks++;
    if (selc !== 4 || selo !== 4'b0001) begin
      errors++; $display("FAIL write_sel: got %0d cycles sel=%b required 4 cycles 0001", selc, selo);
    end
    checks++;
    if (wsc !== 1 || wsat !== 4 || wso !== 16'h0003) begin
      errors++;
      $display("FAIL write_strobe: got %0d cycles at %0d value %h required 1 cycle at 4 value 0003",
               wsc, wsat, wso);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL write_resp: got rdata=%h err=%b required 0 0", rd, er);
    end
    checks++;
    if (s_addr !== 32'h0000_0100 || s_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL write_hold: got addr=%h wdata=%h required 00000100 12345678",
                         s_addr, s_wdata);
    end
    $display("txn write slave0 addr=00000100 lat=%0d strobe=%h", lat, wso);
  endtask

  task automatic test_overlap();
    int lat, selc, wsc, wsat; logic [3:0] selo; logic [15:0] wso; logic [31:0] rd; logic er;
    run_txn(32'hE000_0000, 32'h0, 4'h0, lat, selc, selo, wsc, wso, wsat, rd, er);
    checks++;
    if (selo !== 4'b0100 || selc !== 2) begin
      errors++; $display("FAIL overlap_sel: got sel=%b %0d cycles required 0100 2 cycles", selo, selc);
    end
    checks++;
    if (lat !== 3 || rd !== 32'h2222_2222 || er !== 1'b0) begin
      errors++; $display("FAIL overlap_resp: got lat=%0d rdata=%h err=%b required 3 22222222 0",
                         lat, rd, er);
    end
    $display("txn overlap addr=e0000000 sel=%b rdata=%h", selo, rd);
  endtask

  task automatic test_back_to_back();
    int rcount; int ready_at [2]; logic [31:0] data_at [2];
    logic [3:0] sel7; logic [31:0] addr7;
    rcount = 0; ready_at[0] = 0; ready_at[1] = 0; data_at[0] = 'x; data_at[1] = 'x;
    sel7 = 'x; addr7 = 'x;
    m_addr = 32'h0000_0004; m_wstrb = 4'h0; m_req = 1'b1;
    tick();
    m_addr = 32'h8000_0020;
    for (int c = 1; c <= 12; c++) begin
      if (m_ready && rcount < 2) begin
        ready_at[rcount] = c; data_at[rcount] = m_rdata; rcount++;
      end
      if (c == 6) begin
        checks++;
        if (s_sel !== 4'd0 || m_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap: got sel=%b ready=%b required 0000 0", s_sel, m_ready);
        end
      end
      if (c == 7) begin sel7 = s_sel; addr7 = s_addr; m_req = 1'b0; end
      tick();
    end
    checks++;
    if (ready_at[0] !== 5 || ready_at[1] !== 8) begin
      errors++; $display("FAIL b2b_timing: got ready at %0d,%0d required 5,8", ready_at[0], ready_at[1]);
    end
    checks++;
    if (data_at[0] !== 32'h0BAD_F00D || data_at[1] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_data: got %h,%h required 0badf00d,deadbeef", data_at[0], data_at[1]);
    end
    checks++;
    if (sel7 !== 4'b0010 || addr7 !== 32'h8000_0020) begin
      errors++; $display("FAIL b2b_second: got sel=%b addr=%h required 0010 80000020", sel7, addr7);
    end
    $display("txn back_to_back ready=%0d,%0d data=%h,%h", ready_at[0], ready_at[1], data_at[0], data_at[1]);
  endtask

  task automatic test_miss();
    int lat, selc, wsc, wsat; logic [3:0] selo; logic [15:0] wso; logic [31:0] rd; logic er;
    for (int n = 1; n <= 300; n++) begin
      run_txn(32'h4000_0000, 32'h0, 4'h0, lat, selc, selo, wsc, wso, wsat, rd, er);
      checks++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || selc !== 0) begin
        errors++;
        $display("FAIL miss_resp[%0d]: got lat=%0d err=%b rdata=%h selcycles=%0d required 1 1 0 0",
                 n, lat, er, rd, selc);
      end
      if (n == 1) begin
        checks++;
        if (err_count !== 8'd1 || err_addr !== 32'h4000_0000) begin
          errors++; $display("FAIL miss_first: got cnt=%0d addr=%h required 1 40000000", err_count, err_addr);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255 || err_addr !== 32'h4000_0000) begin
      errors++; $display("FAIL miss_saturate: got cnt=%0d addr=%h required 255 40000000", err_count, err_addr);
    end
    run_txn(32'h4000_0123, 32'h0, 4'h0, lat, selc, selo, wsc, wso, wsat, rd, er);
    checks++;
    if (err_count !== 8'd255 || err_addr !== 32'h4000_0123) begin
      errors++; $display("FAIL miss_after_sat: got cnt=%0d addr=%h required 255 40000123", err_count, err_addr);
    end
    run_txn(32'h8000_0000, 32'h0, 4'h0, lat, selc, selo, wsc, wso, wsat, rd, er);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL miss_then_hit: got err=%b rdata=%h required 0 deadbeef", er, rd);
    end
    $display("txn miss x302 err_count=%0d err_addr=%h", err_count, err_addr);
  endtask

  task automatic test_reset_abort();
    int lat, selc, wsc, wsat, stray; logic [3:0] selo; logic [15:0] wso; logic [31:0] rd; logic er;
    m_addr = 32'hC000_0000; m_wdata = 32'hAAAA_5555; m_wstrb = 4'hF; m_req = 1'b1;
    tick();
    m_req = 1'b0;
    checks++;
    if (s_sel !== 4'b1000) begin errors++; $display("FAIL abort_sel: got %b required 1000", s_sel); end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (s_wstrb !== 16'd0) begin errors++; $display("FAIL abort_rst_cycle: got wstrb=%h required 0", s_wstrb); end
    tick();
    checks++;
    if ({m_ready, m_err, s_sel, s_wstrb} !== 22'd0 ||
        {m_rdata, s_addr, s_wdata, err_addr, err_count} !== 136'd0) begin
      errors++;
      $display("FAIL abort_outputs: got ready=%b err=%b sel=%b wstrb=%h rdata=%h addr=%h wdata=%h eaddr=%h ecnt=%0d required all 0",
               m_ready, m_err, s_sel, s_wstrb, m_rdata, s_addr, s_wdata, err_addr, err_count);
    end
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_wstrb != 16'd0 || m_ready || s_sel != 4'd0) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL abort_stray: got %0d active cycles required 0", stray); end
    run_txn(32'h8000_0040, 32'h0, 4'h0, lat, selc, selo, wsc, wso, wsat, rd, er);
    checks++;
    if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || selo !== 4'b0010) begin
      errors++; $display("FAIL abort_recover: got lat=%0d rdata=%h err=%b sel=%b required 2 deadbeef 0 0010",
                         lat, rd, er, selo);
    end
    $display("txn reset_abort: recovery read rdata=%h", rd);
  endtask

  initial begin
    s_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0BAD_F00D};
    test_reset();
    test_read();
    test_write();
    test_overlap();
    test_back_to_back();
    test_miss();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
